// File: rtl/sobel_window_feeder.sv
// Builds 5x5 raster windows through four line buffers and runs each one through the convolution unit.
// Window-completing pixel to out_valid is CONV_LATENCY+2 edges; pixel input stalls during CONV and OUT, OUT holds until out_ready.
module sobel_window_feeder #(
    parameter int IMG_WIDTH    = 320,
    parameter int IMG_HEIGHT   = 240,
    parameter int CONV_LATENCY = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   pixel_in,
    input  logic         pixel_valid,
    output logic         pixel_ready,
    output logic [199:0] conv_matrix,
    output logic         conv_start,
    input  logic [7:0]   conv_result,
    input  logic         conv_signal,
    output logic [7:0]   out_pixel,
    output logic         out_sign,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int NW = $clog2(CONV_LATENCY + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [NW-1:0] CNT_LAST = NW'(CONV_LATENCY + 1);

    typedef enum logic [1:0] {ACCEPT, CONV, OUT} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [NW-1:0]  cnt_q, cnt_d;
    logic [199:0]   win_q, win_d;
    logic           pixel_ready_q, pixel_ready_d;
    logic           conv_start_q, conv_start_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     out_pixel_q, out_pixel_d;
    logic           out_sign_q, out_sign_d;

    // lb_mem[0] holds the oldest line, lb_mem[3] the line just above the incoming pixel.
    logic [7:0]     lb_mem [4][IMG_WIDTH];
    logic [7:0]     col_vec [5];
    logic           accept;

    assign accept = (state_q == ACCEPT) && pixel_ready_q && pixel_valid;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            col_vec[k] = lb_mem[k][col_q];
        end
        col_vec[4] = pixel_in;

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        out_pixel_d = out_pixel_q;
        out_sign_d  = out_sign_q;

        case (state_q)
            ACCEPT: begin
                if (accept) begin
                    for (int r = 0; r < 5; r++) begin
                        for (int c = 0; c < 4; c++) begin
                            win_d[(r*5+c)*8 +: 8] = win_q[(r*5+c+1)*8 +: 8];
                        end
                        win_d[(r*5+4)*8 +: 8] = col_vec[r];
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (row_q >= RW'(4) && col_q >= CW'(4)) begin
                        state_d = CONV;
                        cnt_d   = '0;
                    end
                end
            end
            CONV: begin
                // conv_start rises one edge after entry so the unit sees a clean low first.
                if (cnt_q == CNT_LAST) begin
                    out_pixel_d = conv_result;
                    out_sign_d  = conv_signal;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase

        pixel_ready_d = (state_d == ACCEPT);
        out_valid_d   = (state_d == OUT);
        conv_start_d  = (state_d == CONV) && (cnt_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ACCEPT;
            col_q         <= '0;
            row_q         <= '0;
            cnt_q         <= '0;
            win_q         <= '0;
            pixel_ready_q <= 1'b0;
            conv_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_pixel_q   <= '0;
            out_sign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            cnt_q         <= cnt_d;
            win_q         <= win_d;
            pixel_ready_q <= pixel_ready_d;
            conv_start_q  <= conv_start_d;
            out_valid_q   <= out_valid_d;
            out_pixel_q   <= out_pixel_d;
            out_sign_q    <= out_sign_d;
        end
    end

    // Line memory is never reset: rows 0-3 of each frame refill it before any window uses it.
    always_ff @(posedge clock) begin
        if (accept) begin
            lb_mem[0][col_q] <= lb_mem[1][col_q];
            lb_mem[1][col_q] <= lb_mem[2][col_q];
            lb_mem[2][col_q] <= lb_mem[3][col_q];
            lb_mem[3][col_q] <= pixel_in;
        end
    end

    assign pixel_ready = pixel_ready_q;
    assign conv_matrix = win_q;
    assign conv_start  = conv_start_q;
    assign out_pixel   = out_pixel_q;
    assign out_sign    = out_sign_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder on a 6x6 frame with a stubbed convolution unit.
module tb_sobel_window_feeder;

    localparam int W   = 6;
    localparam int H   = 6;
    localparam int LAT = 7;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   pixel_in = 8'h00;
    logic         pixel_valid = 1'b0;
    logic         pixel_ready;
    logic [199:0] conv_matrix;
    logic         conv_start;
    logic [7:0]   conv_result;
    logic         conv_signal;
    logic [7:0]   out_pixel;
    logic         out_sign;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    sobel_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CONV_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .conv_matrix(conv_matrix), .conv_start(conv_start),
        .conv_result(conv_result), .conv_signal(conv_signal),
        .out_pixel(out_pixel), .out_sign(out_sign), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // Convolution stub: result appears only after the LAT-th start-high edge.
    int   stub_cnt  = 0;
    logic use_fixed = 1'b0;
    always @(posedge clock) begin
        if (conv_start) begin
            stub_cnt = stub_cnt + 1;
            if (stub_cnt == LAT) begin
                #1;
                conv_result = use_fixed ? 8'hA5 : conv_matrix[103:96];
                conv_signal = use_fixed ? 1'b1 : conv_matrix[96];
            end
        end else begin
            stub_cnt = 0;
            #1;
            conv_result = 8'hxx;
            conv_signal = 1'bx;
        end
    end

    logic [199:0] win_log[$];
    logic [8:0]   out_log[$];
    logic         start_prev = 1'b0;
    always @(negedge clock) begin
        if (conv_start && !start_prev) win_log.push_back(conv_matrix);
        if (out_valid && out_ready) out_log.push_back({out_sign, out_pixel});
        start_prev = conv_start;
    end

    function automatic logic [199:0] exp_win(input int rr, input int cc);
        logic [199:0] w;
        w = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                w[(r*5+c)*8 +: 8] = 8'((rr - 4 + r) * 16 + (cc - 4 + c));
            end
        end
        return w;
    endfunction

    function automatic logic [8:0] exp_out(input int rr, input int cc);
        logic [7:0] ctr;
        ctr = 8'((rr - 2) * 16 + (cc - 2));
        return {ctr[0], ctr};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] p, input int stall);
        int   n;
        logic hs;
        pixel_valid = 1'b0;
        pixel_in    = 8'hEE;
        repeat (stall) tick();
        pixel_in    = p;
        pixel_valid = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 60) begin
            @(negedge clock);
            hs = pixel_ready;
            tick();
            n++;
        end
        pixel_valid = 1'b0;
        checks++;
        if (!hs) begin
            failures++;
            $display("FAIL pixel_handshake pixel=%h accepted=%0d required=1", p, hs);
        end
    endtask

    task automatic send_frame(input int max_stall);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pixel(8'(r * 16 + c), (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (pixel_ready !== 1'b0) begin failures++; $display("FAIL reset_pixel_ready got=%b want=0", pixel_ready); end
        if (conv_start !== 1'b0) begin failures++; $display("FAIL reset_conv_start got=%b want=0", conv_start); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (out_pixel !== 8'h00) begin failures++; $display("FAIL reset_out_pixel got=%h want=00", out_pixel); end
        if (out_sign !== 1'b0) begin failures++; $display("FAIL reset_out_sign got=%b want=0", out_sign); end
        if (conv_matrix !== 200'h0) begin failures++; $display("FAIL reset_conv_matrix got=%h want=0", conv_matrix); end
        reset = 1'b0;
        tick();
        checks++;
        if (pixel_ready !== 1'b1) begin failures++; $display("FAIL release_pixel_ready got=%b want=1", pixel_ready); end
    endtask

    task automatic test_capture_timing();
        int lat;
        int starts;
        int n;
        use_fixed = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i <= 4 * W + 4; i++) begin
            send_pixel(8'((i / W) * 16 + (i % W)), 0);
        end
        lat = 0;
        starts = 0;
        n = 0;
        while (lat == 0 && n < 30) begin
            tick();
            n++;
            if (conv_start) starts++;
            if (out_valid) lat = n;
        end
        checks += 4;
        if (lat != LAT + 2) begin failures++; $display("FAIL capture_latency got=%0d want=%0d", lat, LAT + 2); end
        if (starts != LAT + 1) begin failures++; $display("FAIL conv_start_cycles got=%0d want=%0d", starts, LAT + 1); end
        if (out_pixel !== 8'hA5) begin failures++; $display("FAIL capture_out_pixel got=%h want=a5", out_pixel); end
        if (out_sign !== 1'b1) begin failures++; $display("FAIL capture_out_sign got=%b want=1", out_sign); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pixel !== 8'hA5 || out_sign !== 1'b1 ||
                pixel_ready !== 1'b0 || conv_start !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got v=%b px=%h s=%b rdy=%b st=%b want v=1 px=a5 s=1 rdy=0 st=0",
                         i, out_valid, out_pixel, out_sign, pixel_ready, conv_start);
            end
        end
        out_log.delete();
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b want=0", out_valid); end
        if (pixel_ready !== 1'b1) begin failures++; $display("FAIL release_pixel_ready_after got=%b want=1", pixel_ready); end
        repeat (5) tick();
        checks++;
        if (out_log.size() != 1) begin failures++; $display("FAIL release_transfers got=%0d want=1", out_log.size()); end
        use_fixed = 1'b0;
    endtask

    task automatic test_reset_under_load();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i <= 4 * W + 4; i++) begin
            send_pixel(8'((i / W) * 16 + (i % W)), 0);
        end
        repeat (3) tick();
        checks++;
        if (conv_start !== 1'b1) begin failures++; $display("FAIL load_conv_start got=%b want=1", conv_start); end
        reset = 1'b1;
        tick();
        checks += 3;
        if (conv_start !== 1'b0) begin failures++; $display("FAIL midconv_conv_start got=%b want=0", conv_start); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midconv_out_valid got=%b want=0", out_valid); end
        if (pixel_ready !== 1'b0) begin failures++; $display("FAIL midconv_pixel_ready got=%b want=0", pixel_ready); end
        reset = 1'b0;
        out_log.delete();
        tick();
        checks++;
        if (pixel_ready !== 1'b1) begin failures++; $display("FAIL postreset_pixel_ready got=%b want=1", pixel_ready); end
        repeat (15) tick();
        checks++;
        if (out_log.size() != 0) begin failures++; $display("FAIL discarded_result got=%0d outputs want=0", out_log.size()); end
    endtask

    task automatic test_two_frames();
        int idx;
        win_log.delete();
        out_log.delete();
        out_ready = 1'b1;
        send_frame(0);
        send_frame(0);
        repeat (20) tick();
        checks += 2;
        if (win_log.size() != 8) begin failures++; $display("FAIL frames_window_count got=%0d want=8", win_log.size()); end
        if (out_log.size() != 8) begin failures++; $display("FAIL frames_output_count got=%0d want=8", out_log.size()); end
        for (int k = 0; k < 8; k++) begin
            idx = k % 4;
            if (k < win_log.size()) begin
                checks++;
                if (win_log[k] !== exp_win(4 + idx / 2, 4 + idx % 2)) begin
                    failures++;
                    $display("FAIL frames_window%0d got=%h want=%h", k, win_log[k], exp_win(4 + idx / 2, 4 + idx % 2));
                end
            end
            if (k < out_log.size()) begin
                checks++;
                if (out_log[k] !== exp_out(4 + idx / 2, 4 + idx % 2)) begin
                    failures++;
                    $display("FAIL frames_output%0d got=%h want=%h", k, out_log[k], exp_out(4 + idx / 2, 4 + idx % 2));
                end
            end
        end
    endtask

    task automatic test_input_stalls();
        win_log.delete();
        out_log.delete();
        out_ready = 1'b1;
        send_frame(3);
        repeat (20) tick();
        checks += 2;
        if (win_log.size() != 4) begin failures++; $display("FAIL stall_window_count got=%0d want=4", win_log.size()); end
        if (out_log.size() != 4) begin failures++; $display("FAIL stall_output_count got=%0d want=4", out_log.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < win_log.size()) begin
                checks++;
                if (win_log[k] !== exp_win(4 + k / 2, 4 + k % 2)) begin
                    failures++;
                    $display("FAIL stall_window%0d got=%h want=%h", k, win_log[k], exp_win(4 + k / 2, 4 + k % 2));
                end
            end
            if (k < out_log.size()) begin
                checks++;
                if (out_log[k] !== exp_out(4 + k / 2, 4 + k % 2)) begin
                    failures++;
                    $display("FAIL stall_output%0d got=%h want=%h", k, out_log[k], exp_out(4 + k / 2, 4 + k % 2));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture_timing();
        test_backpressure();
        test_reset_under_load();
        test_two_frames();
        test_input_stalls();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
